// File: rtl/shift_exec_unit.sv
// Two-stage pipelined RV64 shift execution unit (SLL/SRL/SRA and W variants).
// Stage 1 registers the prepared operand, stage 2 registers the shifted result.
module shift_exec_unit #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag
);

  localparam int unsigned AW = $clog2(XLEN);
  localparam int unsigned WW = 32;

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLLW = 3'b100;
  localparam logic [2:0] OP_SRLW = 3'b101;
  localparam logic [2:0] OP_SRAW = 3'b110;

  logic            s1_valid;
  logic [2:0]      s1_op;
  logic [TAGW-1:0] s1_tag;
  logic [XLEN-1:0] s1_operand;
  logic [AW-1:0]   s1_amt;

  logic            s2_adv;
  logic            s1_adv;
  logic [XLEN-1:0] prep_operand;
  logic [AW-1:0]   prep_amt;
  logic [XLEN-1:0] shl;
  logic [XLEN-1:0] shr;
  logic [XLEN-1:0] sra;
  logic [XLEN-1:0] result_c;

  // Only the low amount bits of rs2 matter; the rest are intentionally dropped.
  logic unused_rs2;
  assign unused_rs2 = ^in_rs2[XLEN-1:AW];

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !flush;

  // Operand preparation: W-ops narrow to 32 bits, SRAW keeps the sign for the right shift.
  always_comb begin
    prep_operand = in_rs1;
    prep_amt     = in_rs2[AW-1:0];
    if (in_op[2]) begin
      prep_amt = AW'(in_rs2[4:0]);
      if (in_op[1:0] == 2'b10) begin
        prep_operand = {{(XLEN-WW){in_rs1[WW-1]}}, in_rs1[WW-1:0]};
      end else begin
        prep_operand = {{(XLEN-WW){1'b0}}, in_rs1[WW-1:0]};
      end
    end
  end

  assign shl = s1_operand << s1_amt;
  assign shr = s1_operand >> s1_amt;
  assign sra = XLEN'($signed(s1_operand) >>> s1_amt);

  // Result select; W-ops return the low word sign-extended, reserved ops return 0.
  always_comb begin
    result_c = '0;
    case (s1_op)
      OP_SLL:  result_c = shl;
      OP_SRL:  result_c = shr;
      OP_SRA:  result_c = sra;
      OP_SLLW: result_c = {{(XLEN-WW){shl[WW-1]}}, shl[WW-1:0]};
      OP_SRLW: result_c = {{(XLEN-WW){shr[WW-1]}}, shr[WW-1:0]};
      OP_SRAW: result_c = {{(XLEN-WW){sra[WW-1]}}, sra[WW-1:0]};
      default: result_c = '0;
    endcase
  end

  // Stage 1: operand/decode register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_tag     <= '0;
      s1_operand <= '0;
      s1_amt     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op      <= in_op;
        s1_tag     <= in_tag;
        s1_operand <= prep_operand;
        s1_amt     <= prep_amt;
      end
    end
  end

  // Stage 2: result register; data held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= result_c;
        out_tag    <= s1_tag;
      end
    end
  end

endmodule

// File: doc/shift_exec_unit.md
Name: shift_exec_unit

Overview:
- Two-stage pipelined RV64 shift execution unit in the execute stage.
- Accepts issued shift micro-ops from the decode/issue stage and performs SLL/SRL/SRA and their 32-bit W variants using the team's logical/arithmetic shifter datapath.
- Returns the sign-correct XLEN result with its destination tag to writeback.
- Valid/ready handshakes on both sides; full throughput; flushable.

Parameters:
XLEN, 64, datapath width; only 64 supported for W-ops (W-ops require XLEN=64)
TAGW, 5, destination register tag width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all in-flight ops
in_valid  input  1  issue side presents an op
in_ready  output  1  unit can accept an op this cycle
in_op  input  3  000 SLL, 001 SRL, 010 SRA, 100 SLLW, 101 SRLW, 110 SRAW; 011/111 reserved
in_rs1  input  XLEN  value to shift
in_rs2  input  XLEN  shift amount source (low bits only)
in_tag  input  TAGW  destination tag
out_valid  output  1  result available
out_ready  input  1  writeback accepts result
out_result  output  XLEN  shifted result
out_tag  output  TAGW  tag of out_result

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0, in_ready=1 after reset deasserts. Reset mid-operation discards all in-flight ops; no partial result is ever presented.
- Handshake: transfer on in_valid&&in_ready (input) and out_valid&&out_ready (output). out_result/out_tag hold stable while out_valid&&!out_ready.
- Stage 1 (operand/decode register) captures op, tag, and prepared operand on input transfer:
  - 64-bit ops: operand = in_rs1, amount = in_rs2[5:0].
  - SLLW/SRLW: operand = zero-extended in_rs1[31:0], amount = in_rs2[4:0].
  - SRAW: operand = sign-extended in_rs1[31:0], amount = in_rs2[4:0].
- Stage 2 (result register) computes the shift:
  - SLL/SLLW: left, zero-fill.
  - SRL/SRLW: right, zero-fill.
  - SRA/SRAW: right, fill with operand MSB.
  - W-ops: final result = sign-extension of bit 31 of the shifted value to 64 bits.
  - Reserved ops: result 0, tag still propagated.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput 1 op/cycle.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no combinational path from in_valid).
- Full: both stages valid and out_ready=0 -> in_ready=0, no state changes.
- Simultaneous output drain and input accept in the same cycle is legal; data shifts forward one stage with no bubble.
- Amount 0 returns the operand unchanged (W-ops still sign-extend bit 31). Maximum amount is 63 (64-bit) or 31 (W); higher bits of in_rs2 are ignored.
- flush: at the next edge clears s1_valid and s2_valid. An input presented in the flush cycle is not accepted (in_ready forced 0 while flush=1). Flush outranks out_ready: an output presented in the flush cycle is not transferred.

Test Plan:
1. SLL rs1=0x0000_0000_0000_0010, rs2=4, tag=3 -> 2 cycles later out_valid=1, result=0x0000_0000_0000_0100, tag=3.
2. SRA rs1=0x8000_0000_0000_0010, rs2=4 -> 0xF800_0000_0000_0001; SRL same operands -> 0x0800_0000_0000_0001.
3. W-op sign handling:
   - SLLW rs1=0x0000_0000_0800_0000, rs2=4 -> 0xFFFF_FFFF_8000_0000.
   - SRAW rs1=0x0000_0000_8000_0000, rs2=0x21 (amount 1) -> 0xFFFF_FFFF_C000_0000.
   - SRLW rs1=0xFFFF_FFFF_8000_0000, rs2=31 -> 0x1.
4. Back-to-back stream of 8 SLL ops (rs2=i) with out_ready held 0 for 3 cycles mid-stream -> in_ready drops once both stages are full, no op lost or duplicated, results in order, result held stable while stalled.
5. Two ops in flight, flush=1 for one cycle -> out_valid=0 next cycle and the flushed ops never appear; an op issued the cycle after flush completes normally with 2-cycle latency.
6. Assert reset while stage 2 holds an unaccepted result -> out_valid=0 and out_result=0 immediately; reserved op 011 afterwards -> result 0 with its tag propagated.
